toggle_hs_rx: RTL and testbench
===============================

Name: toggle_hs_rx

Overview:
- Receiving end of the two-phase (toggle) handshake link.
- The sending side drives a T-flip-flop-style request line: each toggle of req_t announces one new word on req_data.
- This block acknowledges each word by toggling ack_t, buffers accepted words in a small first-word-fall-through FIFO, and presents them on a valid/ready output stream.
- It applies back-pressure by withholding the ack toggle while the FIFO is full.

Parameters:
- DATA_W, 8, width of req_data and out_data.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of level; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_t  input  1  request toggle from the sender; each level change means one new word.
- req_data  input  DATA_W  word from the sender; stable whenever req_t != ack_t.
- ack_t  output  1  acknowledge toggle; equals req_t once the pending word is accepted.
- out_data  output  DATA_W  head-of-FIFO word; valid while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  CNT_W  number of words currently stored (0..DEPTH).
- proto_err  output  1  sticky flag: the sender toggled req_t again before the previous word was acked.

Behaviour:
- **Reset** (rst=1 at a clk edge): ack_t=0, level=0, out_valid=0, out_data=0, proto_err=0, read and write pointers = 0, req_prev=0. FIFO contents are don't-care.
  - Reset applied mid-transfer discards stored words and any pending request.
  - The sender is also reset to req_t=0, so no request is pending after reset.
- **Pending**: a request is pending when req_t != ack_t. There is no input synchronizer; req_t is same-clock.
- **Push**: push = pending && (level != DEPTH).
  - On that edge: req_data is written at the write pointer, the write pointer advances (wraps mod DEPTH), and ack_t toggles.
  - At the next cycle req_t == ack_t, so a single toggle can never be accepted twice.
- **Pop**: pop = out_valid && out_ready. The read pointer advances (wraps mod DEPTH).
- **Latency**: a word presented by a req_t toggle seen at edge N (FIFO not full) is written at edge N. ack_t toggles after edge N, and out_valid/out_data reflect it after edge N when the FIFO was empty. There is no bypass path.
- **Full**: full is evaluated from the registered level only.
  - When level == DEPTH, push is blocked even if pop occurs on the same cycle.
  - The ack is then issued on the following cycle, at the earliest.
  - Data and the pending state are held by the sender.
- **Empty**: out_valid=0 and out_ready is ignored. level never underflows.
- **Simultaneous push and pop** (level between 1 and DEPTH-1): both occur and level is unchanged.
  - At level=0 only push is possible, because out_valid=0.
- **level update**: level += push - pop, every cycle.
- **out_data**: always the entry at the read pointer, registered or read combinationally from FIFO storage. It must be stable while out_valid=1 and no pop occurs.
- **proto_err**:
  - req_prev registers req_t every cycle.
  - If req_t != req_prev while a request was already pending in the previous cycle (req_prev != ack_t) and no push happened on that previous edge, proto_err is set.
  - It clears only on rst.
  - A double toggle (req_t returning to equal ack_t) is therefore flagged, and the lost word is not accepted.
- **Widths**: level is CNT_W bits wide; pointers are $clog2(DEPTH) bits wide and wrap naturally.

Test Plan:
1. **Single transfer**: after reset, req_data=8'hA5 and req_t 0->1, out_ready=0.
   - Required: ack_t=1 one edge later; out_valid=1, out_data=A5, level=1.
   - Then out_ready=1 for one cycle: out_valid=0, level=0.
2. **Fill and back-pressure**: send 5 words 01..05 toggle-by-toggle with out_ready=0.
   - Required: first 4 acked and level=4.
   - The 5th stays pending (ack_t != req_t) for 10 idle cycles.
3. **Release from full**: continue scenario 2, raise out_ready for one cycle.
   - Required: pop of 01; level=3 on that edge; 05 pushed and ack_t toggled on the following edge; level=4.
   - Drain order: 02, 03, 04, 05.
4. **Wrap-around and concurrent push/pop**: 12 words 10..1B, sender toggling as soon as acked, out_ready held 1.
   - Required: output sequence 10..1B in order; level never exceeds 2; pointers wrap at least twice.
5. **Protocol error**: toggle req_t 0->1 while out_ready=0 with FIFO full, then toggle 1->0 two cycles later.
   - Required: proto_err=1 and held; that word is never pushed.
6. **Reset mid-operation**: with level=3 and a request pending, assert rst for one cycle.
   - Required: next cycle level=0, out_valid=0, ack_t=0, proto_err=0.
   - A subsequent fresh req_t 0->1 with data 7E is received normally.

Source files
------------

// File: rtl/toggle_hs_rx_if.sv
// toggle_hs_rx_if: signal bundle for the toggle-handshake receiver.
//
// Groups the two-phase request/acknowledge link from the sender and the
// valid/ready output stream towards the consumer.
//   req_t     sender -> rx    request toggle, one level change per word
//   req_data  sender -> rx    word, stable while req_t != ack_t
//   ack_t     rx -> sender    acknowledge toggle
//   out_data  rx -> consumer  head-of-FIFO word
//   out_valid rx -> consumer  FIFO non-empty
//   out_ready consumer -> rx  consumer takes out_data this cycle
//   level     rx -> observer  number of stored words
//   proto_err rx -> observer  sticky sender protocol violation
//
// Modports: slave is the receiver block, master is its environment
// (sender plus consumer).
interface toggle_hs_rx_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              req_t;
    logic [DATA_W-1:0] req_data;
    logic              ack_t;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  level;
    logic              proto_err;

    modport master (
        output req_t,
        output req_data,
        output out_ready,
        input  ack_t,
        input  out_data,
        input  out_valid,
        input  level,
        input  proto_err
    );

    modport slave (
        input  req_t,
        input  req_data,
        input  out_ready,
        output ack_t,
        output out_data,
        output out_valid,
        output level,
        output proto_err
    );

endinterface

// File: rtl/toggle_hs_rx.sv
// toggle_hs_rx: receiving end of a two-phase (toggle) handshake link.
//
// Each level change of req_t announces one word on req_data. The word is
// written into a small first-word-fall-through FIFO and acknowledged by
// toggling ack_t on the same edge. While the FIFO is full the ack toggle is
// withheld, which back-pressures the sender. Stored words leave through a
// valid/ready stream.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  toggle_hs_rx_if.slave (req_t, req_data, ack_t, out_data,
//        out_valid, out_ready, level, proto_err)
//
// Parameters:
//   DATA_W  word width
//   DEPTH   FIFO entries, power of two and >= 2
module toggle_hs_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    toggle_hs_rx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    // Storage and state
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             ack_q, ack_d;
    logic             req_prev_q;
    // A request was pending on the previous edge and was not accepted there.
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    logic pending;
    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        pending  = (bus.req_t != ack_q);
        // Full comes from the registered level only: a pop in the same cycle
        // does not open a slot for a push until the next edge.
        full     = (level_q == FULL_LVL);
        empty    = (level_q == '0);
        push     = pending && !full;
        pop      = !empty && bus.out_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ack_d    = ack_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            ack_d    = ~ack_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase

        stall_d = pending && !push;
        // A further toggle while the previous word was still unacknowledged
        // means a word was overwritten (or withdrawn) by the sender.
        err_d   = err_q || ((bus.req_t != req_prev_q) && stall_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ack_q      <= 1'b0;
            req_prev_q <= 1'b0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ack_q      <= ack_d;
            req_prev_q <= bus.req_t;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset; contents are only visible while out_valid=1.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.req_data;
        end
    end

    // Outputs
    assign bus.ack_t     = ack_q;
    assign bus.out_valid = !empty;
    // Masked to zero while empty so stale storage never leaks out.
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.proto_err = err_q;

    // Level bookkeeping must stay within 0..DEPTH.
    a_level_range: assert property (@(posedge clk) disable iff (rst)
        level_q <= FULL_LVL);

    // Occupancy must agree with the pointer distance (mod DEPTH).
    a_ptr_level: assert property (@(posedge clk) disable iff (rst)
        (wr_ptr_q - rd_ptr_q) == level_q[PTR_W-1:0]);

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Self-checking bench for toggle_hs_rx: a sender model drives req_t/req_data,
// expected words go into a scoreboard queue when sent and are compared when
// the consumer side pops them.
module tb_toggle_hs_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    toggle_hs_rx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    toggle_hs_rx #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit track_max = 1'b0;
    int max_level = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the previous word is acked, then present a new one.
    task automatic send(input logic [DATA_W-1:0] d, input bit expect_push);
        int waited = 0;
        while (bus.ack_t !== bus.req_t && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check_eq("ack_wait", 32'(bus.ack_t), 32'(bus.req_t));
        bus.req_data = d;
        bus.req_t    = ~bus.req_t;
        if (expect_push) exp_q.push_back(d);
    endtask

    // Consumer-side monitor: sampled mid-cycle, inputs change only after posedge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        if (track_max && int'(bus.level) > max_level) max_level <= int'(bus.level);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.req_t     = 1'b0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_ack", 32'(bus.ack_t), 32'd0);
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_err", 32'(bus.proto_err), 32'd0);

        // 1. Single transfer
        bus.req_data = 8'hA5;
        bus.req_t    = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        check_eq("s1_ack", 32'(bus.ack_t), 32'd1);
        check_eq("s1_valid", 32'(bus.out_valid), 32'd1);
        check_eq("s1_data", 32'(bus.out_data), 32'hA5);
        check_eq("s1_level", 32'(bus.level), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("s1_valid_after_pop", 32'(bus.out_valid), 32'd0);
        check_eq("s1_level_after_pop", 32'(bus.level), 32'd0);

        // 2. Fill and back-pressure
        for (int i = 1; i <= 4; i++) begin
            send(DATA_W'(i), 1'b1);
            tick();
            check_eq("s2_ack", 32'(bus.ack_t), 32'(bus.req_t));
        end
        check_eq("s2_level_full", 32'(bus.level), 32'd4);
        send(8'h05, 1'b1);
        repeat (10) tick();
        check_eq("s2_hold_pending", 32'(bus.ack_t != bus.req_t), 32'd1);
        check_eq("s2_level_held", 32'(bus.level), 32'd4);

        // 3. Release from full
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("s3_level_pop", 32'(bus.level), 32'd3);
        check_eq("s3_still_pending", 32'(bus.ack_t != bus.req_t), 32'd1);
        tick();
        check_eq("s3_level_push", 32'(bus.level), 32'd4);
        check_eq("s3_ack", 32'(bus.ack_t), 32'(bus.req_t));
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        check_eq("s3_level_drained", 32'(bus.level), 32'd0);
        check_eq("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4. Wrap-around with concurrent push/pop
        bus.out_ready = 1'b1;
        max_level     = 0;
        track_max     = 1'b1;
        for (int i = 0; i < 12; i++) send(8'h10 + DATA_W'(i), 1'b1);
        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 50) begin
            tick();
            w++;
        end
        track_max     = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("s4_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("s4_max_level_le2", 32'(max_level <= 2), 32'd1);
        check_eq("s4_level", 32'(bus.level), 32'd0);

        // 5. Protocol error
        check_eq("s5_err_clear", 32'(bus.proto_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(8'h20 + DATA_W'(i), 1'b1);
            tick();
        end
        check_eq("s5_level_full", 32'(bus.level), 32'd4);
        bus.req_data = 8'hEE;
        bus.req_t    = ~bus.req_t;
        repeat (2) tick();
        check_eq("s5_err_not_yet", 32'(bus.proto_err), 32'd0);
        bus.req_t = ~bus.req_t;
        tick();
        check_eq("s5_err_set", 32'(bus.proto_err), 32'd1);
        repeat (5) tick();
        check_eq("s5_err_held", 32'(bus.proto_err), 32'd1);
        check_eq("s5_level", 32'(bus.level), 32'd4);
        check_eq("s5_no_ack", 32'(bus.ack_t), 32'(bus.req_t));
        bus.out_ready = 1'b1;
        repeat (6) tick();
        bus.out_ready = 1'b0;
        check_eq("s5_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("s5_level_drained", 32'(bus.level), 32'd0);
        check_eq("s5_err_sticky", 32'(bus.proto_err), 32'd1);

        // 6. Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            send(8'h30 + DATA_W'(i), 1'b1);
            tick();
        end
        check_eq("s6_level3", 32'(bus.level), 32'd3);
        bus.req_data = 8'h55;
        bus.req_t    = ~bus.req_t;
        rst          = 1'b1;
        tick();
        rst       = 1'b0;
        bus.req_t = 1'b0;
        exp_q.delete();
        check_eq("s6_level", 32'(bus.level), 32'd0);
        check_eq("s6_valid", 32'(bus.out_valid), 32'd0);
        check_eq("s6_ack", 32'(bus.ack_t), 32'd0);
        check_eq("s6_err", 32'(bus.proto_err), 32'd0);
        tick();
        bus.req_data = 8'h7E;
        bus.req_t    = 1'b1;
        exp_q.push_back(8'h7E);
        tick();
        check_eq("s6_fresh_ack", 32'(bus.ack_t), 32'd1);
        check_eq("s6_fresh_level", 32'(bus.level), 32'd1);
        check_eq("s6_fresh_data", 32'(bus.out_data), 32'h7E);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("s6_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("s6_level_end", 32'(bus.level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
